// File: rtl/qmath_pkg.sv
// Shared fixed-point definitions for the sign-magnitude Q-format
// arithmetic blocks (sequential multiplier and iterative divider).
package qmath_pkg;

  // Default number format: Q(N-1-Q).Q, sign in bit N-1.
  localparam int Q_DEF = 15;
  localparam int N_DEF = 32;

  // Double-width magnitude used by the shift-add accumulator so that a
  // full-magnitude product can never wrap.
  function automatic int acc_width(input int n);
    return 2 * (n - 1);
  endfunction

  // Pack a sign and a magnitude into sign-magnitude form.
  // On overflow the magnitude pins to all ones and keeps the sign.
  // Otherwise a zero magnitude drops the sign so there is no negative zero.
  // Sized for the shared default word; narrower users take the sign from
  // the top bit and the magnitude from the low bits.
  function automatic logic [N_DEF-1:0] sm_saturate(
    input logic             sign,
    input logic             ovf,
    input logic [N_DEF-2:0] mag
  );
    if (ovf) begin
      return {sign, {(N_DEF-1){1'b1}}};
    end
    return {sign & (|mag), mag};
  endfunction

endpackage

// File: rtl/qmult_seq.sv
// Sequential sign-magnitude fixed-point multiplier.
// One shift-add iteration per clock over the N-1 magnitude bits, then the
// double-width product is truncated by Q bits, saturated and signed.
//
// Handshake: complete=1 means idle and product_out/overflow are valid.
// A start seen high at a rising edge while complete=1 is accepted on that
// edge (operands latched, complete drops). start while complete=0 is
// ignored. complete returns high on the edge that writes the new result,
// N-1 edges after the accepting edge. With start held high a new operation
// is accepted on the very next edge, so complete is high for one cycle.
module qmult_seq
  import qmath_pkg::*;
#(
  parameter int Q = Q_DEF,
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] multiplicand,
  input  logic [N-1:0] multiplier,
  input  logic         start,
  output logic [N-1:0] product_out,
  output logic         overflow,
  output logic         complete
);

  localparam int AW = acc_width(N);
  localparam int CW = $clog2(N);

  // complete doubles as the state bit: 1 = IDLE, 0 = BUSY.
  logic [AW-1:0] acc;
  logic [AW-1:0] mcand;
  logic [N-2:0]  mplier;
  logic          sign;
  logic [CW-1:0] counter;

  logic [AW-1:0]    acc_next;
  logic             ovf_next;
  logic [N-2:0]     mag_next;
  logic [N_DEF-1:0] sat_next;

  // Accumulator after this cycle's conditional add, plus the finished
  // result as it would look if this is the last iteration.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
    ovf_next = |acc_next[AW-1:N-1+Q];
    mag_next = acc_next[N-2+Q:Q];
    sat_next = sm_saturate(sign, ovf_next, (N_DEF-1)'(mag_next));
  end

  // IDLE/BUSY control, shift-add datapath and registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      complete    <= 1'b1;
      product_out <= '0;
      overflow    <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      sign        <= 1'b0;
      counter     <= '0;
    end else if (complete) begin
      if (start) begin
        mcand    <= {{(N-1){1'b0}}, multiplicand[N-2:0]};
        mplier   <= multiplier[N-2:0];
        sign     <= multiplicand[N-1] ^ multiplier[N-1];
        acc      <= '0;
        counter  <= '0;
        complete <= 1'b0;
      end
    end else begin
      acc     <= acc_next;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      counter <= counter + CW'(1);
      if (counter == CW'(N - 2)) begin
        product_out <= {sat_next[N_DEF-1], sat_next[N-2:0]};
        overflow    <= ovf_next;
        complete    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qmult_seq.sv
// Directed bench for qmult_seq at Q=15, N=32.
module tb_qmult_seq;

  localparam int N   = 32;
  localparam int LAT = 31;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  multiplicand;
  logic [N-1:0]  multiplier;
  logic          start;
  logic [N-1:0]  product_out;
  logic          overflow;
  logic          complete;

  int checks;
  int errors;
  int cycles;

  qmult_seq #(.Q(15), .N(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .start        (start),
    .product_out  (product_out),
    .overflow     (overflow),
    .complete     (complete)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // advance one edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // wait for complete, counting edges; bounded
  task automatic wait_done(output int n);
    n = 0;
    while (!complete && n < 100) begin
      step();
      n++;
    end
  endtask

  // issue one operation with start pulsed for one edge, then check it
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_p, input logic exp_o);
    int n;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    step();
    start = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    wait_done(n);
    check({tag, "_lat"}, 32'(n), 32'(LAT));
    check({tag, "_prod"}, product_out, exp_p);
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_o});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    step();
    step();
    rst_n = 1'b1;

    // reset state and idle hold
    check("rst_complete", {31'd0, complete}, 32'd1);
    check("rst_prod", product_out, 32'h0000_0000);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 4; i++) step();
    check("idle_complete", {31'd0, complete}, 32'd1);
    check("idle_prod", product_out, 32'h0000_0000);

    // basic, signs, truncation, overflow
    run_op("basic",  32'h0000_C000, 32'h0001_0000, 32'h0001_8000, 1'b0);
    run_op("neg_pos", 32'h8000_C000, 32'h0001_0000, 32'h8001_8000, 1'b0);
    run_op("neg_neg", 32'h8000_C000, 32'h8001_0000, 32'h0001_8000, 1'b0);
    run_op("neg_zero", 32'h8000_0000, 32'h0000_8000, 32'h0000_0000, 1'b0);
    run_op("trunc0", 32'h0000_0001, 32'h0000_4000, 32'h0000_0000, 1'b0);
    run_op("trunc1", 32'h0000_0003, 32'h0000_4000, 32'h0000_0001, 1'b0);
    run_op("ovf_pos", 32'h4000_0000, 32'h0001_0000, 32'h7FFF_FFFF, 1'b1);
    run_op("ovf_neg", 32'hC000_0000, 32'h0001_0000, 32'hFFFF_FFFF, 1'b1);
    run_op("after_ovf", 32'h0000_C000, 32'h0001_0000, 32'h0001_8000, 1'b0);

    // start pulsed mid-BUSY with new operands is ignored
    multiplicand = 32'h8000_C000;
    multiplier   = 32'h0001_0000;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    multiplicand = 32'h4000_0000;
    multiplier   = 32'h0001_0000;
    start = 1'b1;
    step();
    start = 1'b0;
    check("midbusy_busy", {31'd0, complete}, 32'd0);
    check("midbusy_hold", product_out, 32'h0001_8000);
    wait_done(cycles);
    check("midbusy_lat", 32'(cycles + 6), 32'(LAT));
    check("midbusy_prod", product_out, 32'h8001_8000);
    check("midbusy_ovf", {31'd0, overflow}, 32'd0);

    // reset at iteration 10 aborts the operation
    multiplicand = 32'h0000_C000;
    multiplier   = 32'h0001_0000;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_complete", {31'd0, complete}, 32'd1);
    check("abort_prod", product_out, 32'h0000_0000);
    check("abort_ovf", {31'd0, overflow}, 32'd0);
    step();
    check("abort_idle", {31'd0, complete}, 32'd1);

    // back-to-back with start held high
    multiplicand = 32'h0000_C000;
    multiplier   = 32'h0001_0000;
    start = 1'b1;
    step();
    multiplicand = 32'h0000_0003;
    multiplier   = 32'h0000_4000;
    wait_done(cycles);
    check("b2b1_lat", 32'(cycles), 32'(LAT));
    check("b2b1_prod", product_out, 32'h0001_8000);
    step();
    check("b2b1_one_cycle", {31'd0, complete}, 32'd0);
    multiplicand = 32'h4000_0000;
    multiplier   = 32'h0001_0000;
    wait_done(cycles);
    check("b2b2_lat", 32'(cycles), 32'(LAT));
    check("b2b2_prod", product_out, 32'h0000_0001);
    check("b2b2_ovf", {31'd0, overflow}, 32'd0);
    step();
    check("b2b2_one_cycle", {31'd0, complete}, 32'd0);
    start = 1'b0;
    wait_done(cycles);
    check("b2b3_lat", 32'(cycles), 32'(LAT));
    check("b2b3_prod", product_out, 32'h7FFF_FFFF);
    check("b2b3_ovf", {31'd0, overflow}, 32'd1);
    step();
    check("b2b3_stay_idle", {31'd0, complete}, 32'd1);
    check("b2b3_hold", product_out, 32'h7FFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
